// File: rtl/pmem_arbiter.sv
// pmem_arbiter: serialises I-cache and D-cache line requests onto one pmem port.
// Define ARBITER_RR_EN for round-robin I/D arbitration; default is fixed D-over-I.
module pmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  icache_pmem_read,
    input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
    output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
    output logic                  icache_pmem_resp,
    input  logic                  dcache_pmem_read,
    input  logic                  dcache_pmem_write,
    input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
    input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
    output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
    output logic                  dcache_pmem_resp,
    input  logic                  pmem_resp,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata
);
    typedef enum logic [1:0] {IDLE, I_READ, D_READ, D_WRITE} state_t;
    state_t state_q, state_d;
    logic read_q, read_d, write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic d_req, grant_d, grant_i;
    assign d_req = dcache_pmem_read | dcache_pmem_write;
`ifdef ARBITER_RR_EN
    // last_grant_q: 1 = D was granted last, 0 = I
    logic last_grant_q, last_grant_d;
    assign grant_d = d_req & (!icache_pmem_read | !last_grant_q);
    assign last_grant_d = (state_q == IDLE && (grant_d || grant_i)) ? grant_d : last_grant_q;
    // remember which port won the most recent grant
    always_ff @(posedge clk) last_grant_q <= rst ? 1'b0 : last_grant_d;
`else
    assign grant_d = d_req;
`endif
    assign grant_i = icache_pmem_read & !grant_d;
    // grant in IDLE and latch the request; hold it until memory completes
    always_comb begin
        state_d = state_q;
        read_d  = read_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (state_q == IDLE) begin
            if (grant_d) begin
                state_d = dcache_pmem_write ? D_WRITE : D_READ;
                read_d  = !dcache_pmem_write;
                write_d = dcache_pmem_write;
                addr_d  = dcache_pmem_address;
                wdata_d = dcache_pmem_write ? dcache_pmem_wdata : wdata_q;
            end else if (grant_i) begin
                state_d = I_READ;
                read_d  = 1'b1;
                addr_d  = icache_pmem_address;
            end
        end else if (pmem_resp) begin
            state_d = IDLE;
            read_d  = 1'b0;
            write_d = 1'b0;
        end
    end
    // state and registered pmem request outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end
    assign pmem_read         = read_q;
    assign pmem_write        = write_q;
    assign pmem_address      = addr_q;
    assign pmem_wdata        = wdata_q;
    assign icache_pmem_rdata = pmem_rdata;
    assign dcache_pmem_rdata = pmem_rdata;
    assign icache_pmem_resp  = (state_q == I_READ) & pmem_resp;
    assign dcache_pmem_resp  = (state_q == D_READ || state_q == D_WRITE) & pmem_resp;
endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Sits directly downstream of the split L1 caches (instruction cache and data cache) and upstream of the single 256-bit physical memory port.
- Accepts line-granular read requests from the I-cache, and read/write requests from the D-cache.
- Serialises them onto the pmem interface one transaction at a time, then routes the response back to the requester.
- Registers all pmem-side request outputs so cache combinational paths never reach memory directly.

Parameters:
ADDR_WIDTH, 32, byte address width on all ports
LINE_WIDTH, 256, cache line width in bits

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
icache_pmem_read  in  1  I-cache line read request, held until icache_pmem_resp
icache_pmem_address  in  ADDR_WIDTH  I-cache line address (line-aligned)
icache_pmem_rdata  out  LINE_WIDTH  line data to I-cache
icache_pmem_resp  out  1  one-cycle completion pulse to I-cache
dcache_pmem_read  in  1  D-cache line read request, held until dcache_pmem_resp
dcache_pmem_write  in  1  D-cache line writeback request, held until dcache_pmem_resp
dcache_pmem_address  in  ADDR_WIDTH  D-cache line address (line-aligned)
dcache_pmem_wdata  in  LINE_WIDTH  writeback line data
dcache_pmem_rdata  out  LINE_WIDTH  line data to D-cache
dcache_pmem_resp  out  1  one-cycle completion pulse to D-cache
pmem_resp  in  1  physical memory completion
pmem_rdata  in  LINE_WIDTH  physical memory read data, valid with pmem_resp
pmem_read  out  1  read request to physical memory
pmem_write  out  1  write request to physical memory
pmem_address  out  ADDR_WIDTH  request address to physical memory
pmem_wdata  out  LINE_WIDTH  write data to physical memory

Behaviour:
- Reset values:
  - state = IDLE.
  - pmem_read, pmem_write, icache_pmem_resp and dcache_pmem_resp are 0.
  - pmem_address and pmem_wdata are 0.
  - Under ARBITER_RR_EN, last_grant = I.
- States: IDLE, I_READ, D_READ, D_WRITE.
- IDLE:
  - Samples requests every cycle.
  - On a grant, latches the address (plus wdata for D_WRITE) into the output registers and moves to the granted state.
  - pmem_read or pmem_write rises in the cycle after the request is first sampled (1-cycle request latency).
- Default priority (fixed):
  - D-cache wins over I-cache.
  - dcache_pmem_write wins over dcache_pmem_read.
  - Read and write asserted together from the D-cache is a protocol error; it is treated as a write.
- Served state:
  - pmem_read/pmem_write, pmem_address and pmem_wdata are held stable until pmem_resp.
  - Requester address/data changes during service are ignored.
- Completion (pmem_resp=1 in a served state):
  - The matching cache resp is asserted combinationally in that same cycle; the other cache's resp stays 0.
  - The next state is IDLE.
  - pmem_read/pmem_write are 0 in the following cycle (mandatory 1-cycle bubble between transactions).
- rdata routing:
  - Both icache_pmem_rdata and dcache_pmem_rdata are driven from pmem_rdata at all times.
  - Only the resp pulse is qualified.
- pmem_resp while in IDLE: ignored; no resp is forwarded and no state change occurs.
- Requester obligations:
  - Hold the request until resp.
  - Deassert or change the request by the cycle after resp.
  - A request still asserted in IDLE is a new request.
- Reset mid-transaction: the next state is IDLE and pmem outputs deassert next cycle. The outstanding pmem transaction is abandoned, and memory is expected to be reset alongside.
- Back-to-back transactions: a D writeback followed immediately by a D fill is granted in the IDLE cycle after the writeback resp.
- Throughput: at most one transaction per (memory latency + 2) cycles.

Optional Feature:
- ARBITER_RR_EN defined:
  - Round-robin between I and D when both request in the same IDLE cycle.
  - The port not granted last wins.
  - A 1-bit last_grant register updates on each grant.
  - Write-over-read ordering inside the D port is unchanged.
- ARBITER_RR_EN undefined: fixed D-over-I priority; no last_grant register is present.

Test Plan:
- I read only, addr 0x0000_0060, memory latency 3 →
  - pmem_read=1 and pmem_address=0x60 from the cycle after the request.
  - icache_pmem_resp pulses once with icache_pmem_rdata equal to the memory line.
  - dcache_pmem_resp stays 0.
- D write, addr 0x0000_1000, wdata 0xA5 repeated →
  - pmem_write=1 and pmem_wdata=0xA5… held stable until pmem_resp.
  - dcache_pmem_resp is a single-cycle pulse.
  - pmem_write=0 the next cycle.
- I read 0x100 and D read 0x200 raised in the same cycle, fixed priority →
  - D served first (pmem_address=0x200).
  - One bubble cycle.
  - Then I served (0x100).
  - Each resp pulses exactly once.
- Same simultaneous stimulus repeated 4 times with ARBITER_RR_EN →
  - Grants alternate D, I, D, I, … with no starvation.
- Requester changes icache_pmem_address from 0x100 to 0x300 mid-service →
  - pmem_address stays 0x100 until pmem_resp.
- rst asserted during D_READ, then a spurious pmem_resp in IDLE →
  - pmem_read=0 after the reset cycle.
  - No resp forwarded to either cache.
  - A fresh I request is served normally.
